// File: rtl/soc_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : soc_interconnect -- round-robin N-master / M-slave shared bus
//            with base/mask decode, registered response and slave timeout.
// Revision : 1.0
// ============================================================================
module soc_interconnect #(
    parameter int                      N_MASTERS      = 2,
    parameter int                      N_SLAVES       = 2,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE     = {32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK     = {32'hFFFF_FF00, 32'hFFC0_0000},
    parameter int                      TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_MASTERS-1:0]       m_req,
    input  logic [N_MASTERS-1:0]       m_we,
    input  logic [N_MASTERS*32-1:0]    m_addr,
    input  logic [N_MASTERS*32-1:0]    m_wdata,
    input  logic [N_MASTERS*4-1:0]     m_wstrb,
    output logic [N_MASTERS*32-1:0]    m_rdata,
    output logic [N_MASTERS-1:0]       m_ready,
    output logic [N_MASTERS-1:0]       m_error,
    output logic [N_SLAVES-1:0]        s_req,
    output logic                       s_we,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [N_SLAVES*32-1:0]     s_rdata,
    input  logic [N_SLAVES-1:0]        s_ready
);

    localparam int c_gnt_w = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int c_sel_w = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last  = (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_gnt_w-1:0] c_gnt_reset = c_gnt_w'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_gnt_w-1:0]   grant_q, grant_d;
    logic [c_gnt_w-1:0]   last_q, last_d;
    logic [c_sel_w-1:0]   sel_q, sel_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;

    logic                 w_arb_hi_found;
    logic [c_gnt_w-1:0]   w_arb_hi;
    logic [c_gnt_w-1:0]   w_arb_lo;
    logic [c_gnt_w-1:0]   w_arb_gnt;
    logic                 w_req_we;
    logic [31:0]          w_req_addr;
    logic [31:0]          w_req_wdata;
    logic [3:0]           w_req_wstrb;
    logic                 w_dec_hit;
    logic [c_sel_w-1:0]   w_dec_sel;
    logic                 w_sel_ready;
    logic [31:0]          w_sel_rdata;

    // Round-robin: lowest requester above last_q, else lowest requester overall.
    always_comb begin
        w_arb_hi_found = 1'b0;
        w_arb_hi       = '0;
        w_arb_lo       = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                w_arb_lo = c_gnt_w'(i);
                if (i > int'(last_q)) begin
                    w_arb_hi_found = 1'b1;
                    w_arb_hi       = c_gnt_w'(i);
                end
            end
        end
        w_arb_gnt = w_arb_hi_found ? w_arb_hi : w_arb_lo;
    end

    always_comb begin
        w_req_we    = 1'b0;
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (c_gnt_w'(i) == w_arb_gnt) begin
                w_req_we    = m_we[i];
                w_req_addr  = m_addr[i*32 +: 32];
                w_req_wdata = m_wdata[i*32 +: 32];
                w_req_wstrb = m_wstrb[i*4 +: 4];
            end
        end
    end

    // Descending scan so the lowest-index match wins on overlapping windows.
    always_comb begin
        w_dec_hit = 1'b0;
        w_dec_sel = '0;
        for (int j = N_SLAVES - 1; j >= 0; j--) begin
            if ((w_req_addr & SLAVE_MASK[j*32 +: 32]) == SLAVE_BASE[j*32 +: 32]) begin
                w_dec_hit = 1'b1;
                w_dec_sel = c_sel_w'(j);
            end
        end
    end

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            if (c_sel_w'(j) == sel_q) begin
                w_sel_ready = s_ready[j];
                w_sel_rdata = s_rdata[j*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|m_req) begin
                    grant_d = w_arb_gnt;
                    last_d  = w_arb_gnt;
                    sel_d   = w_dec_sel;
                    we_d    = w_req_we;
                    addr_d  = w_req_addr;
                    wdata_d = w_req_wdata;
                    wstrb_d = w_req_wstrb;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = ~w_dec_hit;
                    state_d = w_dec_hit ? S_ACTIVE : S_RESP;
                end
            end
            S_ACTIVE: begin
                if (w_sel_ready) begin
                    rdata_d = we_q ? 32'h0 : w_sel_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == c_cnt_last)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so no input-to-output path exists.
    always_comb begin
        m_ready = '0;
        m_error = '0;
        m_rdata = '0;
        s_req   = '0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (state_q == S_RESP) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (c_gnt_w'(i) == grant_q) begin
                    m_ready[i]          = 1'b1;
                    m_error[i]          = err_q;
                    m_rdata[i*32 +: 32] = rdata_q;
                end
            end
        end
        if (state_q == S_ACTIVE) begin
            for (int j = 0; j < N_SLAVES; j++) begin
                if (c_sel_w'(j) == sel_q) begin
                    s_req[j] = 1'b1;
                end
            end
            s_we    = we_q;
            s_addr  = addr_q;
            s_wdata = wdata_q;
            s_wstrb = wstrb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= c_gnt_reset;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_interconnect -- vector table, reset/contention sequences
//            and randomized traffic against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_soc_interconnect;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int TO = 4;
    localparam logic [NS*32-1:0] BASE = {32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF_FF00, 32'hFFC0_0000};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_req, m_we;
    logic [NM*32-1:0]  m_addr, m_wdata, m_rdata;
    logic [NM*4-1:0]   m_wstrb;
    logic [NM-1:0]     m_ready, m_error;
    logic [NS-1:0]     s_req, s_ready;
    logic              s_we;
    logic [31:0]       s_addr, s_wdata;
    logic [3:0]        s_wstrb;
    logic [NS*32-1:0]  s_rdata;

    always #5 clk = ~clk;

    soc_interconnect #(
        .N_MASTERS      (NM),
        .N_SLAVES       (NS),
        .SLAVE_BASE     (BASE),
        .SLAVE_MASK     (MASK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_error (m_error),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    // Pending master requests (model view) and round-robin pointer.
    bit          pend    [NM];
    logic        p_we    [NM];
    logic [31:0] p_addr  [NM];
    logic [31:0] p_wdata [NM];
    logic [3:0]  p_wstrb [NM];
    int          model_last;

    // Slave responder configuration and per-transaction log.
    bit          use_fixed, noise_en;
    int          fixed_lat;
    logic [31:0] fixed_data;
    bit          log_seen, log_multi;
    int          log_idx, log_cycles, log_lat;
    logic        log_we;
    logic [31:0] log_addr, log_wdata, log_data;
    logic [3:0]  log_wstrb;
    int          wcnt     [NS];
    int          cur_lat  [NS];
    logic [31:0] cur_data [NS];

    int n_pass = 0;
    int n_total = 0;
    int order_q[$];

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] data;
        int          es;
        logic [31:0] erd;
        logic        eerr;
        int          egap;
        int          ecyc;
    } vec_t;
    vec_t tbl[9];

    task automatic clear_log();
        log_seen = 1'b0; log_multi = 1'b0; log_idx = -1; log_cycles = 0; log_lat = 0;
        log_we = 1'b0; log_addr = '0; log_wdata = '0; log_data = '0; log_wstrb = '0;
    endtask

    // Slave responder: answers once s_req has been high for lat+1 cycles.
    initial begin
        s_ready = '0;
        s_rdata = '0;
        for (int j = 0; j < NS; j++) begin
            wcnt[j] = 0; cur_lat[j] = 0; cur_data[j] = '0;
        end
        forever begin
            @(negedge clk);
            if ($countones(s_req) > 1) log_multi = 1'b1;
            for (int j = 0; j < NS; j++) begin
                if (s_req[j]) begin
                    if (wcnt[j] == 0) begin
                        cur_lat[j]  = use_fixed ? fixed_lat : int'($urandom_range(0, 5));
                        cur_data[j] = use_fixed ? fixed_data : 32'($urandom);
                        log_seen  = 1'b1;
                        log_idx   = j;
                        log_we    = s_we;
                        log_addr  = s_addr;
                        log_wdata = s_wdata;
                        log_wstrb = s_wstrb;
                        log_lat   = cur_lat[j];
                        log_data  = cur_data[j];
                    end
                    wcnt[j]++;
                    log_cycles++;
                    s_ready[j] = (wcnt[j] > cur_lat[j]);
                    s_rdata[j*32 +: 32] = cur_data[j];
                end else begin
                    wcnt[j] = 0;
                    s_ready[j] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    s_rdata[j*32 +: 32] = 32'($urandom);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            m_req[i]             = pend[i];
            m_we[i]              = p_we[i];
            m_addr[i*32 +: 32]   = p_addr[i];
            m_wdata[i*32 +: 32]  = p_wdata[i];
            m_wstrb[i*4 +: 4]    = p_wstrb[i];
        end
    endtask

    task automatic set_txn(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws);
        pend[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = wd; p_wstrb[i] = ws;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] r;
        k = $urandom_range(0, 9);
        r = 32'($urandom);
        if (k < 5)       return r & 32'h003F_FFFC;
        else if (k < 8)  return 32'h1000_0000 | (r & 32'h0000_00FC);
        else if (k == 8) return 32'h1000_0100 | (r & 32'h0000_00FC);
        else             return 32'h2000_0000 | (r & 32'h0FFF_FFFC);
    endfunction

    task automatic new_txn(input int i);
        set_txn(i, 1'($urandom_range(0, 1)), rand_addr(), 32'($urandom), 4'($urandom));
    endtask

    function automatic int decode(input logic [31:0] a);
        int r;
        r = -1;
        for (int j = NS - 1; j >= 0; j--)
            if ((a & MASK[j*32 +: 32]) == BASE[j*32 +: 32]) r = j;
        return r;
    endfunction

    function automatic int rr_pick();
        int r, c;
        r = -1;
        for (int k = NM; k >= 1; k--) begin
            c = (model_last + k) % NM;
            if (pend[c]) r = c;
        end
        return (r < 0) ? 0 : r;
    endfunction

    // Counts negedges until some m_ready is seen; aborts to the summary if none.
    task automatic wait_ready(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (m_ready == '0 && gap < 40);
        if (m_ready == '0) begin
            n_total++;
            $display("FAIL ready_timeout: no m_ready after %0d cycles, required within 40", gap);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    endtask

    task automatic check_txn(input string tag, input int em, input int es, input logic [31:0] erd,
                             input logic eerr, input int egap, input int gap, input int ecyc,
                             input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
        logic [NM-1:0] oh;
        oh = '0;
        oh[em] = 1'b1;
        chk({tag, ".ready"}, m_ready, oh);
        chk({tag, ".error"}, m_error, eerr ? oh : '0);
        for (int i = 0; i < NM; i++)
            chk($sformatf("%s.rdata%0d", tag, i), m_rdata[i*32 +: 32], (i == em) ? erd : 32'h0);
        chk({tag, ".latency"}, gap, egap);
        if (es < 0) begin
            chk({tag, ".no_sreq"}, log_seen, 0);
        end else begin
            chk({tag, ".sreq_seen"}, log_seen, 1);
            chk({tag, ".slave"}, log_idx, es);
            chk({tag, ".onehot"}, log_multi, 0);
            chk({tag, ".sreq_cycles"}, log_cycles, ecyc);
            chk({tag, ".s_we"}, log_we, we);
            chk({tag, ".s_addr"}, log_addr, addr);
            chk({tag, ".s_wdata"}, log_wdata, wdata);
            chk({tag, ".s_wstrb"}, log_wstrb, wstrb);
        end
        clear_log();
    endtask

    // Model-checked run: expectations come from round-robin/decode/latency rules.
    task automatic run_seq(input int ntx, input bit rnd, input bit b2b_start);
        int gap, pick, es, ecyc, egap, obs;
        logic [31:0] erd;
        logic eerr;
        bit b2b, any;
        b2b = b2b_start;
        for (int t = 0; t < ntx; t++) begin
            wait_ready(gap);
            pick = rr_pick();
            es = decode(p_addr[pick]);
            if (es < 0) begin
                erd = '0; eerr = 1'b1; egap = 1; ecyc = 0;
            end else if (log_lat < TO) begin
                erd = p_we[pick] ? 32'h0 : log_data; eerr = 1'b0; egap = log_lat + 2; ecyc = log_lat + 1;
            end else begin
                erd = '0; eerr = 1'b1; egap = TO + 1; ecyc = TO;
            end
            if (b2b) egap++;
            obs = -1;
            for (int i = 0; i < NM; i++) if (m_ready[i]) obs = i;
            order_q.push_back(obs);
            check_txn($sformatf("txn%0d", t), pick, es, erd, eerr, egap, gap, ecyc,
                      p_we[pick], p_addr[pick], p_wdata[pick], p_wstrb[pick]);
            model_last = pick;
            if (t == ntx - 1) begin
                for (int i = 0; i < NM; i++) pend[i] = 1'b0;
            end else if (rnd) begin
                if ($urandom_range(0, 3) != 0) new_txn(pick);
                else pend[pick] = 1'b0;
                any = 1'b0;
                for (int i = 0; i < NM; i++) any |= pend[i];
                if (!any) new_txn(int'($urandom_range(0, NM - 1)));
            end
            drive();
            b2b = 1'b1;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};

        //               m  we  addr           wdata         strb     lat data           es erd            err gap cyc
        tbl[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,        4'hF,    1, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF, 1'b0, 3, 2};
        tbl[1] = '{1, 1'b1, 32'h1000_0000, 32'h41,       4'b0001, 0, 32'h5555_AAAA,  1, 32'h0,         1'b0, 2, 1};
        tbl[2] = '{0, 1'b0, 32'h2000_0000, 32'h0,        4'hF,    0, 32'h1111_1111, -1, 32'h0,         1'b1, 1, 0};
        tbl[3] = '{0, 1'b0, 32'h0000_0040, 32'h0,        4'hF,    9, 32'h2222_2222,  0, 32'h0,         1'b1, 5, 4};
        tbl[4] = '{1, 1'b0, 32'h1000_00FC, 32'h0,        4'hF,    3, 32'h1234_5678,  1, 32'h1234_5678, 1'b0, 5, 4};
        tbl[5] = '{0, 1'b0, 32'h003F_FFFC, 32'h0,        4'hF,    0, 32'hCAFE_F00D,  0, 32'hCAFE_F00D, 1'b0, 2, 1};
        tbl[6] = '{1, 1'b0, 32'h0040_0000, 32'h0,        4'hF,    0, 32'h0,         -1, 32'h0,         1'b1, 1, 0};
        tbl[7] = '{0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF,   2, 32'h3333_3333,  0, 32'h0,         1'b0, 4, 3};
        tbl[8] = '{1, 1'b0, 32'h1000_0100, 32'h0,        4'hF,    0, 32'h0,         -1, 32'h0,         1'b1, 1, 0};

        rst_n = 1'b0;
        use_fixed = 1'b1; noise_en = 1'b0; fixed_lat = 0; fixed_data = '0;
        model_last = NM - 1;
        for (int i = 0; i < NM; i++) set_txn(i, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < NM; i++) pend[i] = 1'b0;
        drive();
        clear_log();

        repeat (2) @(negedge clk);
        chk("reset.s_req", s_req, 0);
        chk("reset.s_we", s_we, 0);
        chk("reset.s_addr", s_addr, 0);
        chk("reset.s_wdata", s_wdata, 0);
        chk("reset.s_wstrb", s_wstrb, 0);
        chk("reset.m_ready", m_ready, 0);
        chk("reset.m_error", m_error, 0);
        chk("reset.m_rdata", m_rdata, 0);
        rst_n = 1'b1;

        noise_en = 1'b1;
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            fixed_lat = tbl[v].lat;
            fixed_data = tbl[v].data;
            set_txn(tbl[v].m, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].wstrb);
            drive();
            wait_ready(gap);
            check_txn($sformatf("vec%0d", v), tbl[v].m, tbl[v].es, tbl[v].erd, tbl[v].eerr,
                      tbl[v].egap, gap, tbl[v].ecyc, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].wstrb);
            pend[tbl[v].m] = 1'b0;
            drive();
            model_last = tbl[v].m;
        end

        // Reset while ACTIVE: s_req must fall before the next clock edge.
        @(negedge clk);
        noise_en = 1'b0; fixed_lat = 20;
        set_txn(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        drive();
        repeat (2) @(negedge clk);
        chk("rstmid.s_req_before", s_req, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.s_req_async", s_req, 0);
        chk("rstmid.s_addr", s_addr, 0);
        chk("rstmid.m_ready", m_ready, 0);
        chk("rstmid.m_error", m_error, 0);
        chk("rstmid.m_rdata", m_rdata, 0);
        pend[1] = 1'b0;
        drive();
        @(negedge clk);
        chk("rstmid.held_ready", m_ready, 0);
        rst_n = 1'b1;
        model_last = NM - 1;
        clear_log();
        repeat (2) begin
            @(negedge clk);
            chk("rstmid.no_response", m_ready, 0);
            chk("rstmid.idle_sreq", s_req, 0);
        end

        // Both masters request continuously after reset: master 0 first.
        fixed_lat = 0; fixed_data = 32'h0BAD_F00D;
        set_txn(0, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        set_txn(1, 1'b0, 32'h1000_0004, 32'h0, 4'hF);
        drive();
        order_q.delete();
        run_seq(4, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr.order%0d", k), (k < order_q.size()) ? order_q[k] : -1, exp_order[k]);

        // Randomized multi-master traffic with random slave latencies.
        @(negedge clk);
        use_fixed = 1'b0; noise_en = 1'b1;
        for (int i = 0; i < NM; i++) if ($urandom_range(0, 3) != 0) new_txn(i);
        if (!pend[0] && !pend[1]) new_txn(0);
        drive();
        run_seq(150, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
